// File: rtl/mux_nway_arb.sv
// Registered WAYS-to-1 multiplexer with valid/ready handshakes on every channel.
// The arbitration mode is selectable: fixed select or round-robin.
module mux_nway_arb #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_sel
);

  logic [WIDTH-1:0] chan_data [WAYS];
  logic [WAYS-1:0]  fix_grant;
  logic [WAYS-1:0]  hi_req;
  logic [WAYS-1:0]  rr_grant;
  logic [WAYS-1:0]  grant;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  grant_idx;

  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SELW-1:0]  out_sel_reg, out_sel_next;
  logic             out_valid_reg, out_valid_next;
  logic [SELW-1:0]  ptr_reg, ptr_next;

  // hi_req holds the requesters at or above the pointer; they take priority
  // over the wrapped-around ones below it.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign fix_grant[gi] = in_valid[gi] && (sel == SELW'(gi));
      assign hi_req[gi]    = in_valid[gi] && (SELW'(gi) >= ptr_reg);
    end
  endgenerate

  // x & -x isolates the lowest set bit, giving a one-hot or zero grant.
  assign rr_grant = (|hi_req) ? (hi_req & (~hi_req + WAYS'(1)))
                              : (in_valid & (~in_valid + WAYS'(1)));
  assign grant    = mode ? rr_grant : fix_grant;

  assign can_load = !out_valid_reg || out_ready;
  assign load     = (|grant) && can_load && !reset;
  assign in_ready = grant & {WAYS{can_load && !reset}};

  // The grant is one-hot, so OR-reduction acts as the data mux and index encoder.
  always_comb begin
    grant_data = '0;
    grant_idx  = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (grant[i]) begin
        grant_data = grant_data | chan_data[i];
        grant_idx  = grant_idx | SELW'(i);
      end
    end
  end

  always_comb begin
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (load) begin
      out_data_next  = grant_data;
      out_sel_next   = grant_idx;
      out_valid_next = 1'b1;
      if (mode) begin
        ptr_next = (grant_idx == SELW'(WAYS - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Directed bench for mux_nway_arb (WIDTH=16, WAYS=8): a table of single-cycle vectors
// plus hand-written backpressure and mid-stream reset sequences.
module tb_mux_nway_arb;

  localparam int WIDTH = 16;
  localparam int WAYS  = 8;
  localparam int SELW  = 3;

  logic                  clk;
  logic                  reset;
  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SELW-1:0]       out_sel;

  int n_cmp = 0;
  int n_bad = 0;
  int n_vec = 0;

  mux_nway_arb #(.WIDTH(WIDTH), .WAYS(WAYS), .SELW(SELW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        md;
    logic [2:0]  sl;
    logic [7:0]  vld;
    logic        ordy;
    logic        ds;      // 0: channels 3/7 carry FFD8/DA2C, 1: all channels 1111*i
    logic [7:0]  e_rdy;   // in_ready during the cycle
    logic        e_ov;    // registered outputs after the edge
    logic [15:0] e_od;
    logic [2:0]  e_os;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic md, logic [2:0] sl, logic [7:0] vld,
                              logic ordy, logic ds, logic [7:0] e_rdy, logic e_ov,
                              logic [15:0] e_od, logic [2:0] e_os);
    vec_t v;
    v.rst = rst; v.md = md; v.sl = sl; v.vld = vld; v.ordy = ordy; v.ds = ds;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    return v;
  endfunction

  task automatic set_data(input logic ds);
    for (int i = 0; i < WAYS; i++) in_data[i*WIDTH +: WIDTH] = 16'(16'h1111 * i);
    if (!ds) begin
      in_data[3*WIDTH +: WIDTH] = 16'hFFD8;
      in_data[7*WIDTH +: WIDTH] = 16'hDA2C;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks in_ready, then the registered outputs.
  task automatic apply(input vec_t v, input string tag);
    reset     = v.rst;
    mode      = v.md;
    sel       = v.sl;
    in_valid  = v.vld;
    out_ready = v.ordy;
    set_data(v.ds);
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({tag, ".out_data"}, 32'(out_data), 32'(v.e_od));
    check({tag, ".out_sel"}, 32'(out_sel), 32'(v.e_os));
    $display("vec %0d %s: rst=%0b mode=%0b sel=%0d vld=%02h ordy=%0b -> rdy=%02h ov=%0b od=%04h os=%0d",
             n_vec, tag, v.rst, v.md, v.sl, v.vld, v.ordy, in_ready, out_valid, out_data, out_sel);
    n_vec++;
  endtask

  initial begin
    // reset with everything requesting
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 0, 8'h00, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 0, 8'h00, 0, 16'h0000, 0));
    // fixed select
    tbl.push_back(mk(0, 0, 3, 8'hFF, 1, 0, 8'h08, 1, 16'hFFD8, 3));
    tbl.push_back(mk(0, 0, 7, 8'hFF, 1, 0, 8'h80, 1, 16'hDA2C, 7));
    tbl.push_back(mk(0, 0, 7, 8'h7F, 1, 0, 8'h00, 0, 16'hDA2C, 7));
    // round-robin fairness, ptr starts at 0
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 1, 8'(1 << (k % 8)), 1,
                       16'(16'h1111 * (k % 8)), 3'(k % 8)));
    // sparse 2/6 from ptr=1, then 7/0 wrap from ptr=7
    tbl.push_back(mk(0, 1, 0, 8'h44, 1, 1, 8'h04, 1, 16'h2222, 2));
    tbl.push_back(mk(0, 1, 0, 8'h44, 1, 1, 8'h40, 1, 16'h6666, 6));
    tbl.push_back(mk(0, 1, 0, 8'h44, 1, 1, 8'h04, 1, 16'h2222, 2));
    tbl.push_back(mk(0, 1, 0, 8'h44, 1, 1, 8'h40, 1, 16'h6666, 6));
    tbl.push_back(mk(0, 1, 0, 8'h81, 1, 1, 8'h80, 1, 16'h7777, 7));
    tbl.push_back(mk(0, 1, 0, 8'h81, 1, 1, 8'h01, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 8'h81, 1, 1, 8'h80, 1, 16'h7777, 7));

    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    set_data(1'b0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // backpressure: ptr=0, stream 0..3, stall 3 cycles on 3333, release to 4444
    for (int k = 0; k < 4; k++)
      apply(mk(0, 1, 0, 8'hFF, 1, 1, 8'(1 << k), 1, 16'(16'h1111 * k), 3'(k)),
            $sformatf("bp_fill%0d", k));
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 0, 8'hFF, 0, 1, 8'h00, 1, 16'h3333, 3), $sformatf("bp_stall%0d", k));
    apply(mk(0, 1, 0, 8'hFF, 1, 1, 8'h10, 1, 16'h4444, 4), "bp_release");

    // mid-stream reset with a word buffered; ptr returns to 0
    apply(mk(1, 1, 0, 8'hFF, 1, 1, 8'h00, 0, 16'h0000, 0), "mid_reset");
    apply(mk(0, 1, 0, 8'hFF, 1, 1, 8'h01, 1, 16'h0000, 0), "post_reset0");
    apply(mk(0, 1, 0, 8'hFF, 1, 1, 8'h02, 1, 16'h1111, 1), "post_reset1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
